// File: rtl/spi_master_burst_sequencer.sv
// Burst feeder for SPI_FPGA_MASTER: TX FIFO -> one LAUNCH/CS/ACTION_DONE handshake per word -> RX FIFO.
// Optional watchdog on a stuck transfer is built when SEQ_TIMEOUT_EN is defined.
module spi_master_burst_sequencer #(
    parameter int PACK_LENGTH    = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET_N,
    input  logic [PACK_LENGTH-1:0] IN_TX_DATA,
    input  logic                   IN_TX_VALID,
    output logic                   OUT_TX_READY,
    output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
    output logic                   OUT_RX_VALID,
    input  logic                   IN_RX_READY,
    output logic                   OUT_MASTER_LAUNCH,
    output logic [PACK_LENGTH-1:0] OUT_MASTER_DATA,
    input  logic                   IN_MASTER_CS,
    input  logic [PACK_LENGTH-1:0] IN_MASTER_RECEIVE_DATA,
    input  logic                   IN_MASTER_ACTION_DONE,
    output logic                   OUT_BUSY,
    output logic                   OUT_TIMEOUT,
    input  logic                   IN_CLEAR_FLAGS
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_STORE, S_GAP} state_t;
    state_t r_state, w_state_nxt;

    logic [PACK_LENGTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [PACK_LENGTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW:0]            r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [AW:0]            w_tx_wr_nxt, w_tx_rd_nxt;
    logic                   r_tx_ready;
    logic                   w_tx_push, w_tx_pop, w_tx_empty, w_tx_full_nxt;
    logic                   w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;

    logic                   r_launch, w_launch_nxt;
    logic [PACK_LENGTH-1:0] r_mdata, w_mdata_nxt;
    logic [PACK_LENGTH-1:0] r_cap, w_cap_nxt;
    logic                   r_done_q, w_done_rise;
    logic                   w_tmo_hit;

    // TX FIFO: ready is the registered complement of the next-cycle full flag
    assign w_tx_push     = IN_TX_VALID && r_tx_ready;
    assign w_tx_empty    = (r_tx_wr == r_tx_rd);
    assign w_tx_wr_nxt   = r_tx_wr + {{AW{1'b0}}, w_tx_push};
    assign w_tx_rd_nxt   = r_tx_rd + {{AW{1'b0}}, w_tx_pop};
    assign w_tx_full_nxt = (w_tx_wr_nxt[AW] != w_tx_rd_nxt[AW]) &&
                           (w_tx_wr_nxt[AW-1:0] == w_tx_rd_nxt[AW-1:0]);
    assign OUT_TX_READY  = r_tx_ready;

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_ready <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= '0;
        end else begin
            if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= IN_TX_DATA;
            r_tx_wr    <= w_tx_wr_nxt;
            r_tx_rd    <= w_tx_rd_nxt;
            r_tx_ready <= !w_tx_full_nxt;
        end
    end

    assign w_rx_empty   = (r_rx_wr == r_rx_rd);
    assign w_rx_full    = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
    assign w_rx_pop     = !w_rx_empty && IN_RX_READY;
    assign OUT_RX_VALID = !w_rx_empty;
    assign OUT_RX_DATA  = r_rx_mem[r_rx_rd[AW-1:0]];

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wr[AW-1:0]] <= r_cap;
                r_rx_wr <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
        end
    end

    assign w_done_rise = IN_MASTER_ACTION_DONE && !r_done_q;

`ifdef SEQ_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_timeout;

    assign w_tmo_hit   = ((r_state == S_LAUNCH) || (r_state == S_WAIT_DONE)) &&
                         (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign OUT_TIMEOUT = r_timeout;

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_state_nxt == S_LAUNCH) r_cnt <= '0;
            else if (r_state == S_LAUNCH || r_state == S_WAIT_DONE) r_cnt <= r_cnt + 1'b1;
            if (w_tmo_hit) r_timeout <= 1'b1;
            else if (IN_CLEAR_FLAGS) r_timeout <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused    = IN_CLEAR_FLAGS ^ (TIMEOUT_CYCLES == 0);
    assign w_tmo_hit   = 1'b0;
    assign OUT_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_state  <= S_IDLE;
            r_launch <= 1'b0;
            r_mdata  <= '0;
            r_cap    <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_launch <= w_launch_nxt;
            r_mdata  <= w_mdata_nxt;
            r_cap    <= w_cap_nxt;
            r_done_q <= IN_MASTER_ACTION_DONE;
        end
    end

    // GAP waits for CS high and DONE low so a lingering completion cannot retrigger a launch
    always_comb begin
        w_state_nxt  = r_state;
        w_launch_nxt = r_launch;
        w_mdata_nxt  = r_mdata;
        w_cap_nxt    = r_cap;
        w_tx_pop     = 1'b0;
        w_rx_push    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty && !w_rx_full) begin
                    w_tx_pop     = 1'b1;
                    w_mdata_nxt  = r_tx_mem[r_tx_rd[AW-1:0]];
                    w_launch_nxt = 1'b1;
                    w_state_nxt  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (w_tmo_hit) begin
                    w_launch_nxt = 1'b0;
                    w_state_nxt  = S_GAP;
                end else if (!IN_MASTER_CS) begin
                    w_launch_nxt = 1'b0;
                    w_state_nxt  = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_GAP;
                end else if (w_done_rise) begin
                    w_cap_nxt   = IN_MASTER_RECEIVE_DATA;
                    w_state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                w_rx_push   = 1'b1;
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (IN_MASTER_CS && !IN_MASTER_ACTION_DONE) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign OUT_MASTER_LAUNCH = r_launch;
    assign OUT_MASTER_DATA   = r_mdata;
    assign OUT_BUSY          = (r_state != S_IDLE) || !w_tx_empty;

endmodule

// File: tb/tb_spi_master_burst_sequencer.sv
// Scoreboarded bench for spi_master_burst_sequencer with a behavioural master/slave stub
// whose slave answers each word with (tx ^ 8'hB9).
module tb_spi_master_burst_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       m_launch;
    logic [7:0] m_data;
    logic       m_cs = 1'b1;
    logic [7:0] m_recv = '0;
    logic       m_done = 1'b0;
    logic       busy;
    logic       timeout;
    logic       clear_flags = 1'b0;

    always #5 clk = ~clk;

    spi_master_burst_sequencer #(
        .PACK_LENGTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .IN_CLOCK(clk), .IN_RESET_N(rst_n),
        .IN_TX_DATA(tx_data), .IN_TX_VALID(tx_valid), .OUT_TX_READY(tx_ready),
        .OUT_RX_DATA(rx_data), .OUT_RX_VALID(rx_valid), .IN_RX_READY(rx_ready),
        .OUT_MASTER_LAUNCH(m_launch), .OUT_MASTER_DATA(m_data),
        .IN_MASTER_CS(m_cs), .IN_MASTER_RECEIVE_DATA(m_recv),
        .IN_MASTER_ACTION_DONE(m_done),
        .OUT_BUSY(busy), .OUT_TIMEOUT(timeout), .IN_CLEAR_FLAGS(clear_flags)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    int   st = 0;
    int   cnt = 0;
    int   cs_delay = 2;
    int   xfer_len = 8;
    bit   stub_hang = 1'b0;
    int   cs_falls = 0;
    int   launch_hi = 0;
    logic prev_launch = 1'b0;
    logic [7:0] lat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Master + slave stub: CS falls cs_delay clocks after LAUNCH, DONE after xfer_len clocks
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                m_cs = 1'b1; m_done = 1'b0; st = 0; cnt = 0;
            end else begin
                case (st)
                    0: if (m_launch) begin st = 1; cnt = 1; end
                    1: begin
                        if (!stub_hang && cnt >= cs_delay) begin
                            m_cs = 1'b0;
                            lat = m_data;
                            cs_falls++;
                            if (exp_tx.size() == 0) fail_now("master_data_unexpected");
                            else check("master_data", m_data, exp_tx.pop_front());
                            st = 2; cnt = 0;
                        end else cnt++;
                    end
                    2: begin
                        if (cnt >= xfer_len - 1) begin
                            m_recv = lat ^ 8'hB9;
                            m_done = 1'b1;
                            st = 3;
                        end else cnt++;
                    end
                    3: begin m_cs = 1'b1; st = 4; end
                    default: begin m_done = 1'b0; st = 0; end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard whenever the host side pops the RX FIFO
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_launch) launch_hi++;
            if (m_launch && !prev_launch) check("launch_cs_high", m_cs, 1);
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) fail_now("rx_unexpected");
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
        end
        prev_launch = m_launch;
    end

    task automatic push(input logic [7:0] d, input logic [7:0] rx_exp, input bit track);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
        if (!tx_ready) fail_now("push_wait");
        tx_data = d;
        tx_valid = 1'b1;
        if (track) begin exp_tx.push_back(d); exp_rx.push_back(rx_exp); end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || rx_valid || st != 0) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) fail_now(name);
    endtask

    task automatic set_rx_ready(input logic v);
        @(posedge clk); #1;
        rx_ready = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] burst_tx [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] burst_rx [4] = '{8'hB8, 8'hBB, 8'hBA, 8'hBD};
    logic [7:0] bp_tx [8] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    logic [7:0] bp_rx [8] = '{8'hA9, 8'h99, 8'h89, 8'hF9, 8'hE9, 8'hD9, 8'hC9, 8'h39};

    initial begin
        int c0;
        int n;
        // Reset held for 10 clocks
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_launch", m_launch, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_mdata", m_data, 0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_rx_ready(1'b1);

        // Single word
        c0 = cs_falls;
        push(8'hEA, 8'h53, 1'b1);
        wait_drain("single_drain");
        check("single_cs_pulses", cs_falls - c0, 1);
        check("single_busy", busy, 0);
        check("single_sb_empty", exp_rx.size(), 0);

        // Back-to-back burst of four
        c0 = cs_falls;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("burst_ready", tx_ready, 1);
            tx_data = burst_tx[i];
            tx_valid = 1'b1;
            exp_tx.push_back(burst_tx[i]);
            exp_rx.push_back(burst_rx[i]);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        wait_drain("burst_drain");
        check("burst_cs_pulses", cs_falls - c0, 4);
        check("burst_busy", busy, 0);
        check("burst_sb_empty", exp_rx.size(), 0);

        // Handshake: CS falls 7 clocks after LAUNCH
        cs_delay = 7;
        launch_hi = 0;
        push(8'hC3, 8'h7A, 1'b1);
        check("launch_lat_k", m_launch, 0);
        @(posedge clk); #1;
        check("launch_lat_k1", m_launch, 1);
        wait_drain("hs_drain");
        check("hs_launch_cycles", launch_hi, 8);
        cs_delay = 2;

        // RX backpressure: four transfers then stall with one word queued
        c0 = cs_falls;
        set_rx_ready(1'b0);
        for (int i = 0; i < 5; i++) push(bp_tx[i], bp_rx[i], 1'b1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("bp_cs_pulses4", cs_falls - c0, 4);
        check("bp_rx_valid", rx_valid, 1);
        check("bp_busy", busy, 1);
        check("bp_launch", m_launch, 0);
        for (int i = 5; i < 8; i++) push(bp_tx[i], bp_rx[i], 1'b1);
        check("bp_tx_full", tx_ready, 0);
        set_rx_ready(1'b1);
        set_rx_ready(1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("bp_cs_pulses5", cs_falls - c0, 5);
        check("bp_tx_ready_again", tx_ready, 1);
        set_rx_ready(1'b1);
        wait_drain("bp_drain");
        check("bp_cs_pulses8", cs_falls - c0, 8);
        check("bp_sb_empty", exp_rx.size(), 0);

        // Asynchronous reset while waiting for DONE, with a word still queued
        xfer_len = 30;
        push(8'h11, 8'hA8, 1'b1);
        push(8'h22, 8'h9B, 1'b1);
        n = 0;
        while (st != 2 && n < 200) begin @(posedge clk); #1; n++; end
        if (st != 2) fail_now("rst_mid_wait");
        @(posedge clk); @(posedge clk); #3;
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_launch", m_launch, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        exp_tx.delete();
        exp_rx.delete();
        @(negedge clk);
        rst_n = 1'b1;
        xfer_len = 8;

        // Asynchronous reset while LAUNCH is high
        cs_delay = 20;
        push(8'h33, 8'h8A, 1'b1);
        n = 0;
        while (!m_launch && n < 100) begin @(posedge clk); #1; n++; end
        if (!m_launch) fail_now("rst_launch_wait");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_launch", m_launch, 0);
        repeat (3) @(posedge clk);
        exp_tx.delete();
        exp_rx.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cs_delay = 2;

        // Recovery after reset
        c0 = cs_falls;
        push(8'h5A, 8'hE3, 1'b1);
        wait_drain("recover_drain");
        check("recover_cs_pulses", cs_falls - c0, 1);
        check("recover_sb_empty", exp_rx.size(), 0);

`ifdef SEQ_TIMEOUT_EN
        stub_hang = 1'b1;
        launch_hi = 0;
        push(8'h77, 8'h00, 1'b0);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("tmo_launch_cycles", launch_hi, 16);
        check("tmo_flag", timeout, 1);
        check("tmo_rx_valid", rx_valid, 0);
        check("tmo_busy", busy, 0);
        stub_hang = 1'b0;
        st = 0;
        @(posedge clk); #1;
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        check("tmo_cleared", timeout, 0);
`else
        check("timeout_tied_low", timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
